// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the 8-bit processor.
//   Owns the PC, which drives the instruction-memory address directly from a
//   register. The word returned by the combinational instruction memory is
//   captured into the IF/ID register for the decoder. The stage also handles
//   start/halt, decode stalls and taken-branch redirects. Every redirect
//   inserts exactly one bubble.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | after reset; PC and IF/ID hold; waits for iStart
//   RUN     | fetching; one action per edge: halt > branch > stall > normal
//   HALTED  | HALT reached decode; everything frozen until Reset
//
// Ports
//   Clock          in   rising-edge clock
//   Reset          in   synchronous, active-high reset
//   iStart         in   leave IDLE and begin fetching
//   iStall         in   decode cannot accept; hold PC and IF/ID
//   iBranchTaken   in   branch in ID is taken
//   iBranchOffset  in   signed offset of the branch in ID
//   iHalt          in   instruction in ID is HALT
//   iIMemData      in   instruction memory read data for oIMemAddr
//   oIMemAddr      out  current PC / instruction memory address
//   oIdInstr       out  IF/ID instruction word
//   oIdPC          out  PC of oIdInstr
//   oIdValid       out  oIdInstr is real (0 = bubble)
//   oHalted        out  stage is HALTED
//   oFetchCount    out  words captured into IF/ID since reset, saturating
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned              PC_WIDTH    = 10,
    parameter int unsigned              INSTR_WIDTH = 16,
    parameter int unsigned              OFF_WIDTH   = 6,
    parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        iStart,
    input  logic                        iStall,
    input  logic                        iBranchTaken,
    input  logic [OFF_WIDTH-1:0]        iBranchOffset,
    input  logic                        iHalt,
    input  logic [INSTR_WIDTH-1:0]      iIMemData,
    output logic [PC_WIDTH-1:0]         oIMemAddr,
    output logic [INSTR_WIDTH-1:0]      oIdInstr,
    output logic [PC_WIDTH-1:0]         oIdPC,
    output logic                        oIdValid,
    output logic                        oHalted,
    output logic [15:0]                 oFetchCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]     id_instr_q, id_instr_d;
    logic [PC_WIDTH-1:0]        id_pc_q, id_pc_d;
    logic                       id_valid_q, id_valid_d;
    logic [15:0]                fetch_cnt_q, fetch_cnt_d;

    logic [PC_WIDTH-1:0]        off_sext;
    logic [PC_WIDTH-1:0]        branch_target;

    // Target is relative to the instruction after the branch; the sum is kept
    // at PC_WIDTH bits so overflow wraps around the address space.
    assign off_sext      = {{(PC_WIDTH-OFF_WIDTH){iBranchOffset[OFF_WIDTH-1]}}, iBranchOffset};
    assign branch_target = id_pc_q + PC_WIDTH'(1) + off_sext;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            IDLE: begin
                // No capture on the start edge; the first fetch happens in RUN.
                if (iStart) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A bubble in ID never halts or redirects.
                if (iHalt && id_valid_q) begin
                    state_d    = HALTED;
                    id_valid_d = 1'b0;
                end else if (iBranchTaken && id_valid_q) begin
                    // Flush the wrong-path word; stall is irrelevant here.
                    pc_d       = branch_target;
                    id_valid_d = 1'b0;
                end else if (!iStall) begin
                    id_instr_d = iIMemData;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                    pc_d       = pc_q + PC_WIDTH'(1);
                    if (fetch_cnt_q != 16'hFFFF) begin
                        fetch_cnt_d = fetch_cnt_q + 16'd1;
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign oIMemAddr   = pc_q;
    assign oIdInstr    = id_instr_q;
    assign oIdPC       = id_pc_q;
    assign oIdValid    = id_valid_q;
    assign oHalted     = (state_q == HALTED);
    assign oFetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios followed by random control traffic. Each stimulus cycle
//   advances a behavioural model of the fetch stage and queues the outputs
//   expected after the next edge; an independent monitor pops and compares
//   them shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic        iStall;
    logic        iBranchTaken;
    logic [5:0]  iBranchOffset;
    logic        iHalt;
    logic [15:0] iIMemData;
    logic [9:0]  oIMemAddr;
    logic [15:0] oIdInstr;
    logic [9:0]  oIdPC;
    logic        oIdValid;
    logic        oHalted;
    logic [15:0] oFetchCount;

    always #5 Clock = ~Clock;

    fetch_stage #(
        .PC_WIDTH    (10),
        .INSTR_WIDTH (16),
        .OFF_WIDTH   (6),
        .RESET_PC    (10'd0)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchOffset (iBranchOffset),
        .iHalt         (iHalt),
        .iIMemData     (iIMemData),
        .oIMemAddr     (oIMemAddr),
        .oIdInstr      (oIdInstr),
        .oIdPC         (oIdPC),
        .oIdValid      (oIdValid),
        .oHalted       (oHalted),
        .oFetchCount   (oFetchCount)
    );

    logic [15:0] imem [1024];
    assign iIMemData = imem[oIMemAddr];

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] instr;
        logic [9:0]  idpc;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    int          m_pc;
    int          m_idpc;
    int          m_cnt;
    logic [15:0] m_instr;
    bit          m_valid;

    task automatic step(input bit rst, input bit st, input bit stall,
                        input bit br, input int off, input bit halt);
        int   o;
        obs_t e;
        @(negedge Clock);
        Reset         = rst;
        iStart        = st;
        iStall        = stall;
        iBranchTaken  = br;
        iBranchOffset = 6'(off);
        iHalt         = halt;

        o = off & 63;
        if (o >= 32) o = o - 64;

        if (rst) begin
            m_mode = 0; m_pc = 0; m_idpc = 0; m_cnt = 0;
            m_instr = 16'h0; m_valid = 0;
        end else if (m_mode == 0) begin
            if (st) m_mode = 1;
        end else if (m_mode == 1) begin
            if (halt && m_valid) begin
                m_mode  = 2;
                m_valid = 0;
            end else if (br && m_valid) begin
                m_pc    = (m_idpc + 1 + o + 1024) % 1024;
                m_valid = 0;
            end else if (!stall) begin
                m_instr = imem[m_pc];
                m_idpc  = m_pc;
                m_valid = 1;
                m_pc    = (m_pc + 1) % 1024;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
        end

        e.addr   = 10'(m_pc);
        e.instr  = m_instr;
        e.idpc   = 10'(m_idpc);
        e.valid  = m_valid;
        e.halted = (m_mode == 2);
        e.cnt    = 16'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic normal();
        step(0, 0, 0, 0, 0, 0);
    endtask

    obs_t mon_exp;
    obs_t mon_got;

    initial begin
        forever begin
            @(posedge Clock);
            #2;
            if (exp_q.size() > 0) begin
                mon_exp        = exp_q.pop_front();
                mon_got.addr   = oIMemAddr;
                mon_got.instr  = oIdInstr;
                mon_got.idpc   = oIdPC;
                mon_got.valid  = oIdValid;
                mon_got.halted = oHalted;
                mon_got.cnt    = oFetchCount;
                n_tests++;
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got addr=%0d instr=%h idpc=%0d valid=%b halted=%b cnt=%0d, expected addr=%0d instr=%h idpc=%0d valid=%b halted=%b cnt=%0d",
                             $time, mon_got.addr, mon_got.instr, mon_got.idpc, mon_got.valid,
                             mon_got.halted, mon_got.cnt, mon_exp.addr, mon_exp.instr,
                             mon_exp.idpc, mon_exp.valid, mon_exp.halted, mon_exp.cnt);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 16'($urandom);
        Reset = 1'b1; iStart = 0; iStall = 0; iBranchTaken = 0;
        iBranchOffset = '0; iHalt = 0;
        m_mode = 0; m_pc = 0; m_idpc = 0; m_cnt = 0; m_instr = '0; m_valid = 0;

        // Reset, single-cycle start, straight-line fetch.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) normal();

        // Stall for 3 cycles with oIdPC=5, then resume.
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        normal();
        normal();

        // Run to oIdPC=10 and branch by -4 -> target 7, one bubble.
        for (int k = 0; k < 20 && !(m_valid && m_idpc == 10); k++) normal();
        step(0, 0, 1, 1, -4, 0);
        step(0, 0, 0, 1, 5, 0);   // branch during the bubble is ignored
        normal();
        normal();

        // Branch near the top of memory wraps: 1020 + 1 + 8 -> 5.
        for (int k = 0; k < 1100 && !(m_valid && m_idpc == 1020); k++) normal();
        step(0, 0, 0, 1, 8, 0);
        normal();
        normal();

        // Sequential wrap 1023 -> 0.
        for (int k = 0; k < 1100 && m_pc != 1023; k++) normal();
        normal();
        normal();

        // Reset in the middle of a stall.
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) normal();

        // Halt wins over branch and stall; outputs then stay frozen.
        step(0, 0, 1, 1, 7, 1);
        for (int k = 0; k < 10; k++)
            step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                 int'($urandom_range(0, 63)), $urandom_range(0, 1));
        step(1, 0, 0, 0, 0, 0);
        normal();

        // Random control traffic.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 63)),
                 $urandom_range(0, 29) == 0);
        end

        @(posedge Clock);
        #4;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
